immd_gen_pipe: RTL and testbench

Pipelined, parametrised immediate generator for the decode stage. Accepts raw instruction words over a valid/ready handshake, classifies the instruction type from the opcode, and produces the XLEN-wide sign-extended immediate with a 1-cycle registered latency. A 2-entry skid buffer gives full throughput under backpressure. A flush clears in-flight entries on branch redirect.

---
 rtl/immd_gen_pipe_pkg.sv | 32 +++
 rtl/immd_gen_pipe_if.sv | 30 +++
 rtl/immd_gen_pipe_immd_decode.sv | 70 +++++++
 rtl/immd_gen_pipe.sv | 101 ++++++++++
 tb/tb_immd_gen_pipe.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/immd_gen_pipe_pkg.sv
// Shared definitions for the immediate generator: instruction type codes,
// base and RV64 opcode constants, and a small funct3 helper.
package immd_gen_pipe_pkg;

  typedef enum logic [2:0] {
    R_TYPE = 3'd0,
    I_TYPE = 3'd1,
    S_TYPE = 3'd2,
    B_TYPE = 3'd3,
    U_TYPE = 3'd4,
    J_TYPE = 3'd5
  } imm_type_e;

  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;

  // SLLI / SRLI / SRAI share funct3 001 and 101 within the OP-IMM groups.
  function automatic logic is_shift_f3(input logic [2:0] funct3);
    return (funct3 == 3'b001) || (funct3 == 3'b101);
  endfunction

endpackage

// File: rtl/immd_gen_pipe_if.sv
// Input/output stream bundle of the immediate generator, plus the flush
// strobe. master = producer/consumer side, slave = the generator itself.
interface immd_gen_pipe_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) ();

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_immd;
  logic [2:0]       out_type;
  logic             out_illegal;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output flush, in_valid, in_instr, in_tag, out_ready,
    input  in_ready, out_valid, out_immd, out_type, out_illegal, out_tag
  );

  modport slave (
    input  flush, in_valid, in_instr, in_tag, out_ready,
    output in_ready, out_valid, out_immd, out_type, out_illegal, out_tag
  );

endinterface

// File: rtl/immd_gen_pipe_immd_decode.sv
// Combinational opcode classifier and immediate extractor. XLEN is 32 or 64;
// RV64_OPS may only be set together with XLEN = 64.
module immd_decode
  import immd_gen_pipe_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int RV64_OPS = 0
) (
  input  logic [31:0]     instr,
  output imm_type_e       typ,
  output logic            illegal,
  output logic [XLEN-1:0] immd
);

  logic [6:0] opc;
  logic       shift_grp;

  assign opc = instr[6:0];

  // Only the OP-IMM groups carry a shamt in place of a signed immediate.
  assign shift_grp = ((opc == OPC_OP_IMM) || ((RV64_OPS != 0) && (opc == OPC_OP_IMM_32)))
                     && is_shift_f3(instr[14:12]);

  // Classify the opcode and build the sign-extended immediate.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned, which would infer a latch.
    typ     = R_TYPE;
    illegal = 1'b0;
    immd    = '0;
    case (opc)
      OPC_OP: ;
      OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM: begin
        typ  = I_TYPE;
        immd = XLEN'($signed(instr[31:20]));
      end
      OPC_OP_IMM_32: begin
        if (RV64_OPS != 0) begin
          typ  = I_TYPE;
          immd = XLEN'($signed(instr[31:20]));
        end else begin
          illegal = 1'b1;
        end
      end
      OPC_OP_32: illegal = (RV64_OPS == 0);
      OPC_STORE: begin
        typ  = S_TYPE;
        immd = XLEN'($signed({instr[31:25], instr[11:7]}));
      end
      OPC_BRANCH: begin
        typ  = B_TYPE;
        immd = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
      end
      OPC_LUI, OPC_AUIPC: begin
        typ  = U_TYPE;
        immd = XLEN'($signed({instr[31:12], 12'b0}));
      end
      OPC_JAL: begin
        typ  = J_TYPE;
        immd = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
      end
      default: illegal = 1'b1;
    endcase
    // The 64-bit OP-IMM shift takes a 6-bit shamt; the word forms take 5 bits.
    if (shift_grp) begin
      if ((XLEN == 64) && (opc == OPC_OP_IMM)) immd = XLEN'(instr[25:20]);
      else                                     immd = XLEN'(instr[24:20]);
    end
  end

endmodule

// File: rtl/immd_gen_pipe.sv
// Decode-stage immediate generator: one registered output entry backed by a
// one-entry skid register, so a held output never costs input throughput.
module immd_gen_pipe
  import immd_gen_pipe_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int TAG_W    = 32,
  parameter int RV64_OPS = 0
) (
  input logic             clk,
  input logic             rst,
  immd_gen_pipe_if.slave  bus
);

  imm_type_e        dec_type;
  logic             dec_illegal;
  logic [XLEN-1:0]  dec_immd;

  logic             out_valid_q;
  logic [XLEN-1:0]  out_immd_q;
  imm_type_e        out_type_q;
  logic             out_illegal_q;
  logic [TAG_W-1:0] out_tag_q;

  logic             skid_valid_q;
  logic [XLEN-1:0]  skid_immd_q;
  imm_type_e        skid_type_q;
  logic             skid_illegal_q;
  logic [TAG_W-1:0] skid_tag_q;

  logic             in_ready_q;
  logic             accept;
  logic             drain;

  immd_decode #(.XLEN(XLEN), .RV64_OPS(RV64_OPS)) u_decode (
    .instr   (bus.in_instr),
    .typ     (dec_type),
    .illegal (dec_illegal),
    .immd    (dec_immd)
  );

  assign accept = bus.in_valid && in_ready_q;
  assign drain  = out_valid_q && bus.out_ready;

  // Output/skid entry movement; flush beats every other update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
      out_valid_q    <= 1'b0;
      out_immd_q     <= '0;
      out_type_q     <= R_TYPE;
      out_illegal_q  <= 1'b0;
      out_tag_q      <= '0;
      skid_valid_q   <= 1'b0;
      skid_immd_q    <= '0;
      skid_type_q    <= R_TYPE;
      skid_illegal_q <= 1'b0;
      skid_tag_q     <= '0;
      in_ready_q     <= 1'b1;
    end else if (bus.flush) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else if (skid_valid_q) begin
      // in_ready is low here, so only the skid-to-output move can happen.
      if (drain) begin
        out_immd_q    <= skid_immd_q;
        out_type_q    <= skid_type_q;
        out_illegal_q <= skid_illegal_q;
        out_tag_q     <= skid_tag_q;
        skid_valid_q  <= 1'b0;
        in_ready_q    <= 1'b1;
      end
    end else if (accept) begin
      if (!out_valid_q || bus.out_ready) begin
        out_valid_q   <= 1'b1;
        out_immd_q    <= dec_immd;
        out_type_q    <= dec_type;
        out_illegal_q <= dec_illegal;
        out_tag_q     <= bus.in_tag;
      end else begin
        skid_valid_q   <= 1'b1;
        skid_immd_q    <= dec_immd;
        skid_type_q    <= dec_type;
        skid_illegal_q <= dec_illegal;
        skid_tag_q     <= bus.in_tag;
        in_ready_q     <= 1'b0;
      end
    end else if (drain) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_immd    = out_immd_q;
  assign bus.out_type    = out_type_q;
  assign bus.out_illegal = out_illegal_q;
  assign bus.out_tag     = out_tag_q;

endmodule

// File: tb/tb_immd_gen_pipe.sv
// Bench for immd_gen_pipe: an XLEN=32 and an XLEN=64/RV64 instance share the
// same stimulus; each is checked against its own queue-based reference model.
module tb_immd_gen_pipe;

  typedef struct {
    logic [63:0] immd;
    logic [2:0]  typ;
    logic        ill;
    logic [31:0] tag;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_tag;
  logic        out_ready;

  int          n_checks;
  int          n_errors;
  exp_t        q32[$];
  exp_t        q64[$];
  logic [31:0] drained[$];
  bit          last_acc;

  immd_gen_pipe_if #(.XLEN(32), .TAG_W(32)) bus32 ();
  immd_gen_pipe_if #(.XLEN(64), .TAG_W(32)) bus64 ();

  assign bus32.flush     = flush;
  assign bus32.in_valid  = in_valid;
  assign bus32.in_instr  = in_instr;
  assign bus32.in_tag    = in_tag;
  assign bus32.out_ready = out_ready;
  assign bus64.flush     = flush;
  assign bus64.in_valid  = in_valid;
  assign bus64.in_instr  = in_instr;
  assign bus64.in_tag    = in_tag;
  assign bus64.out_ready = out_ready;

  immd_gen_pipe #(.XLEN(32), .TAG_W(32), .RV64_OPS(0)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
  immd_gen_pipe #(.XLEN(64), .TAG_W(32), .RV64_OPS(1)) dut64 (.clk(clk), .rst(rst), .bus(bus64));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Reference: type and immediate straight from the ISA field layouts.
  function automatic exp_t ref_model(input logic [31:0] w, input logic [31:0] tag, input bit x64);
    exp_t        e;
    logic [6:0]  op;
    logic [2:0]  f3;
    longint      v;
    op    = w[6:0];
    f3    = w[14:12];
    v     = 0;
    e.typ = 3'd0;
    e.ill = 1'b0;
    e.tag = tag;
    case (op)
      7'h33: ;
      7'h13, 7'h03, 7'h67, 7'h73: begin e.typ = 3'd1; v = longint'($signed(w[31:20])); end
      7'h1B: if (x64) begin e.typ = 3'd1; v = longint'($signed(w[31:20])); end else e.ill = 1'b1;
      7'h3B: e.ill = !x64;
      7'h23: begin e.typ = 3'd2; v = longint'($signed({w[31:25], w[11:7]})); end
      7'h63: begin e.typ = 3'd3; v = longint'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0})); end
      7'h37, 7'h17: begin e.typ = 3'd4; v = longint'($signed(w[31:12])) * 4096; end
      7'h6F: begin e.typ = 3'd5; v = longint'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0})); end
      default: e.ill = 1'b1;
    endcase
    if ((op == 7'h13 || (x64 && op == 7'h1B)) && (f3 == 3'd1 || f3 == 3'd5))
      v = (x64 && op == 7'h13) ? longint'(w[25:20]) : longint'(w[24:20]);
    e.immd = x64 ? 64'(v) : {32'b0, v[31:0]};
    return e;
  endfunction

  // One clock: note the handshakes seen before the edge, advance both
  // models, then compare both DUTs with the model heads.
  task automatic tick();
    bit          acc32, drn32, acc64, drn64, fl;
    logic [31:0] w, t, otag;
    exp_t        e;
    acc32 = in_valid && bus32.in_ready;
    drn32 = bus32.out_valid && out_ready;
    acc64 = in_valid && bus64.in_ready;
    drn64 = bus64.out_valid && out_ready;
    fl    = flush;
    w     = in_instr;
    t     = in_tag;
    otag  = bus32.out_tag;
    @(posedge clk);
    #1;
    last_acc = acc32 && !fl;
    if (fl) begin
      q32.delete();
      q64.delete();
    end else begin
      if (drn32 && q32.size() > 0) begin
        void'(q32.pop_front());
        drained.push_back(otag);
      end
      if (drn64 && q64.size() > 0) void'(q64.pop_front());
      if (acc32) q32.push_back(ref_model(w, t, 1'b0));
      if (acc64) q64.push_back(ref_model(w, t, 1'b1));
    end
    check("valid32", bus32.out_valid, q32.size() != 0);
    check("ready32", bus32.in_ready, q32.size() < 2);
    check("valid64", bus64.out_valid, q64.size() != 0);
    check("ready64", bus64.in_ready, q64.size() < 2);
    if (q32.size() > 0) begin
      e = q32[0];
      check("immd32", {32'b0, bus32.out_immd}, e.immd);
      check("type32", bus32.out_type, e.typ);
      check("ill32", bus32.out_illegal, e.ill);
      check("tag32", bus32.out_tag, e.tag);
    end
    if (q64.size() > 0) begin
      e = q64[0];
      check("immd64", bus64.out_immd, e.immd);
      check("type64", bus64.out_type, e.typ);
      check("ill64", bus64.out_illegal, e.ill);
      check("tag64", bus64.out_tag, e.tag);
    end
  endtask

  task automatic send(input logic [31:0] w, input logic [31:0] t);
    in_valid = 1'b1;
    in_instr = w;
    in_tag   = t;
    tick();
  endtask

  task automatic drain_all();
    int budget;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    budget    = 0;
    while ((q32.size() > 0 || q64.size() > 0) && budget < 20) begin
      tick();
      budget++;
    end
    if (budget >= 20) check("drain_timeout", 1, 0);
  endtask

  logic [31:0] plan_w[5]   = '{32'hFFF00093, 32'hFE112E23, 32'hFE000EE3, 32'hFFDFF0EF, 32'h800000B7};
  logic [31:0] plan_imm[5] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h80000000};
  logic [2:0]  plan_typ[5] = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd4};
  logic [6:0]  opcs[15]    = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37,
                               7'h17, 7'h6F, 7'h1B, 7'h3B, 7'h7F, 7'h00, 7'h0F};

  initial begin
    int          budget;
    logic [31:0] r;
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    #2;
    check("rst_valid", bus32.out_valid, 0);
    check("rst_ready", bus32.in_ready, 1);
    check("rst_immd", bus32.out_immd, 0);
    check("rst_type", bus32.out_type, 0);
    check("rst_ill", bus32.out_illegal, 0);
    check("rst_tag", bus32.out_tag, 0);
    check("rst_valid64", bus64.out_valid, 0);
    #10 rst = 1'b0;
    @(posedge clk);
    #1;

    // Back-to-back, latency 1, one per cycle.
    for (int i = 0; i < 5; i++) begin
      send(plan_w[i], 32'(i + 1));
      check("plan_immd", bus32.out_immd, plan_imm[i]);
      check("plan_type", bus32.out_type, plan_typ[i]);
    end
    check("lui64", bus64.out_immd, 64'hFFFFFFFF80000000);
    send(32'h43F0D093, 32'h55);
    check("srai64", bus64.out_immd, 64'h000000000000003F);
    check("srai64_type", bus64.out_type, 3'd1);
    check("srai32", bus32.out_immd, 32'h0000001F);
    send(32'h0000007F, 32'hABCD1234);
    check("illegal", bus32.out_illegal, 1);
    check("illegal_immd", bus32.out_immd, 0);
    check("illegal_type", bus32.out_type, 0);
    check("illegal_tag", bus32.out_tag, 32'hABCD1234);
    drain_all();

    // Backpressure: output held, skid filled, third word stalls.
    out_ready = 1'b0;
    send(32'h00500093, 101);
    send(32'h00A00113, 102);
    check("bp_ready", bus32.in_ready, 0);
    check("bp_hold", bus32.out_tag, 101);
    send(32'hFFF00193, 103);
    check("bp_hold2", bus32.out_tag, 101);
    drained.delete();
    out_ready = 1'b1;
    budget    = 0;
    while (in_valid && budget < 10) begin
      tick();
      if (last_acc) in_valid = 1'b0;
      budget++;
    end
    if (budget >= 10) check("bp_timeout", 1, 0);
    drain_all();
    check("bp_count", drained.size(), 3);
    for (int i = 0; i < 3 && i < drained.size(); i++) check("bp_order", drained[i], 32'(101 + i));

    // Flush with both entries full and a third word offered.
    out_ready = 1'b0;
    send(32'h00100093, 201);
    send(32'h00200093, 202);
    flush = 1'b1;
    send(32'h00300093, 203);
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_valid", bus32.out_valid, 0);
    check("flush_ready", bus32.in_ready, 1);
    check("flush_valid64", bus64.out_valid, 0);
    drained.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("flush_none", drained.size(), 0);

    // Asynchronous reset between edges while an entry is held.
    out_ready = 1'b0;
    send(32'h00700093, 301);
    in_valid = 1'b0;
    check("ar_pre", bus32.out_valid, 1);
    #3 rst = 1'b1;
    #1;
    check("ar_valid", bus32.out_valid, 0);
    check("ar_tag", bus32.out_tag, 0);
    check("ar_valid64", bus64.out_valid, 0);
    q32.delete();
    q64.delete();
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(32'h00800093, 302);
    in_valid = 1'b0;
    check("ar_lat_valid", bus32.out_valid, 1);
    check("ar_lat_tag", bus32.out_tag, 302);
    drain_all();

    // Randomised traffic with backpressure and occasional flushes.
    for (int n = 0; n < 3000; n++) begin
      r = $urandom();
      if ($urandom_range(0, 2) == 0) r[14:12] = $urandom_range(0, 1) ? 3'b001 : 3'b101;
      in_instr  = {r[31:7], opcs[$urandom_range(0, 14)]};
      in_tag    = $urandom();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      tick();
    end
    flush = 1'b0;
    drain_all();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
